// File: rtl/lift_group_dispatcher.sv
// lift_group_dispatcher: latches hall calls and assigns each pending call to the
// cheapest in-service car, one call at a time, with a round-robin slot search.
module lift_group_dispatcher #(
  parameter int unsigned N_FLOORS = 8,
  parameter int unsigned N_CARS   = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [N_FLOORS-1:0]                    i_up_rqst,
  input  logic [N_FLOORS-1:0]                    i_dn_rqst,
  input  logic [N_CARS*$clog2(N_FLOORS)-1:0]     i_car_flr,
  input  logic [N_CARS-1:0]                      i_car_dir,
  input  logic [N_CARS-1:0]                      i_car_motion,
  input  logic [N_CARS-1:0]                      i_car_avail,
  input  logic [N_CARS-1:0]                      i_car_up_clr,
  input  logic [N_CARS-1:0]                      i_car_dn_clr,
  output logic [N_CARS*N_FLOORS-1:0]             o_car_up_req,
  output logic [N_CARS*N_FLOORS-1:0]             o_car_dn_req,
  output logic [N_FLOORS-1:0]                    o_up_pending,
  output logic [N_FLOORS-1:0]                    o_dn_pending,
  output logic                                   o_busy
);

  localparam int unsigned FW = $clog2(N_FLOORS);
  localparam int unsigned CW = (N_CARS > 1) ? $clog2(N_CARS) : 1;
  localparam int unsigned NS = 2 * N_FLOORS;
  localparam int unsigned SW = $clog2(NS);
  localparam int unsigned KW = FW + 2;

  typedef enum logic [1:0] {StIdle, StScan, StEval, StGrant} state_e;

  state_e                       r_state;
  logic [SW-1:0]                r_ptr;
  logic [SW-1:0]                r_slot;
  logic [CW-1:0]                r_car_idx;
  logic [CW-1:0]                r_best_car;
  logic [KW-1:0]                r_best_cost;
  logic                         r_best_vld;
  logic [NS-1:0]                r_pend;
  logic [N_CARS-1:0][NS-1:0]    r_asgn;

  logic [NS-1:0]                w_assigned;
  logic [NS-1:0]                w_free;
  logic                         w_found;
  logic [SW-1:0]                w_pick;
  logic [FW-1:0]                w_car_flr;
  logic                         w_car_dir;
  logic                         w_car_mot;
  logic                         w_car_avl;
  logic                         w_call_up;
  logic [FW-1:0]                w_call_flr;
  logic [FW:0]                  w_dist;
  logic                         w_toward;
  logic [KW-1:0]                w_cost;
  logic [N_FLOORS-1:0]          w_up_m;
  logic [N_FLOORS-1:0]          w_dn_m;
  logic [NS-1:0]                w_clr;
  logic [NS-1:0]                w_pend_nxt;
  logic                         w_grant;
  logic [N_CARS-1:0][NS-1:0]    w_asgn_nxt;

  // Slots that are pending but held by no car are candidates for dispatch.
  always_comb begin
    w_assigned = '0;
    for (int unsigned c = 0; c < N_CARS; c++) begin
      w_assigned = w_assigned | r_asgn[c];
    end
    w_free = r_pend & ~w_assigned;
  end

  // Round-robin search for the first free slot after the last granted one.
  always_comb begin
    int unsigned idx;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = 0;
    for (int unsigned i = 0; i < NS; i++) begin
      idx = (32'(r_ptr) + i + 32'd1) % NS;
      if (!w_found && w_free[SW'(idx)]) begin
        w_found = 1'b1;
        w_pick  = SW'(idx);
      end
    end
  end

  // Cost of serving the held slot with the car currently under evaluation.
  always_comb begin
    w_car_flr = '0;
    w_car_dir = 1'b0;
    w_car_mot = 1'b0;
    w_car_avl = 1'b0;
    for (int unsigned c = 0; c < N_CARS; c++) begin
      if (CW'(c) == r_car_idx) begin
        w_car_flr = i_car_flr[c*FW +: FW];
        w_car_dir = i_car_dir[c];
        w_car_mot = i_car_motion[c];
        w_car_avl = i_car_avail[c];
      end
    end
    w_call_up  = (r_slot < SW'(N_FLOORS));
    w_call_flr = w_call_up ? FW'(r_slot) : FW'(r_slot - SW'(N_FLOORS));
    w_dist     = (w_car_flr > w_call_flr) ? ({1'b0, w_car_flr} - {1'b0, w_call_flr})
                                          : ({1'b0, w_call_flr} - {1'b0, w_car_flr});
    // A moving car only avoids the penalty when heading at the call in the call's direction.
    w_toward   = w_car_mot && (w_car_dir == w_call_up) &&
                 (w_call_up ? (w_car_flr < w_call_flr) : (w_car_flr > w_call_flr));
    w_cost     = (!w_car_mot || w_toward) ? KW'(w_dist) : KW'(w_dist) + KW'(N_FLOORS);
  end

  // Next pending/assignment state: press, then clear (clear wins), grant, then drop-out.
  always_comb begin
    w_up_m = i_up_rqst;
    w_up_m[N_FLOORS-1] = 1'b0;
    w_dn_m = i_dn_rqst;
    w_dn_m[0] = 1'b0;
    w_clr = '0;
    for (int unsigned c = 0; c < N_CARS; c++) begin
      if (32'(i_car_flr[c*FW +: FW]) < N_FLOORS) begin
        if (i_car_up_clr[c]) w_clr[SW'(i_car_flr[c*FW +: FW])] = 1'b1;
        if (i_car_dn_clr[c]) w_clr[SW'(i_car_flr[c*FW +: FW]) + SW'(N_FLOORS)] = 1'b1;
      end
    end
    w_pend_nxt = (r_pend | {w_dn_m, w_up_m}) & ~w_clr;
    w_grant    = (r_state == StGrant) && r_best_vld && w_pend_nxt[r_slot];
    for (int unsigned c = 0; c < N_CARS; c++) begin
      w_asgn_nxt[c] = r_asgn[c] & ~w_clr;
      if (w_grant && (r_best_car == CW'(c))) w_asgn_nxt[c][r_slot] = 1'b1;
      if (!i_car_avail[c]) w_asgn_nxt[c] = '0;
    end
  end

  // Call slot registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
      r_asgn <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_asgn <= w_asgn_nxt;
    end
  end

  // Assignment FSM: scan for a slot, evaluate each car in turn, then grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_ptr       <= SW'(NS - 1);
      r_slot      <= '0;
      r_car_idx   <= '0;
      r_best_car  <= '0;
      r_best_cost <= '0;
      r_best_vld  <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (|w_free) r_state <= StScan;
        end
        StScan: begin
          if (w_found) begin
            r_slot     <= w_pick;
            r_car_idx  <= '0;
            r_best_vld <= 1'b0;
            r_state    <= StEval;
          end else begin
            r_state <= StIdle;
          end
        end
        StEval: begin
          if (w_car_avl && (!r_best_vld || (w_cost < r_best_cost))) begin
            r_best_vld  <= 1'b1;
            r_best_cost <= w_cost;
            r_best_car  <= r_car_idx;
          end
          if (r_car_idx == CW'(N_CARS - 1)) r_state <= StGrant;
          else r_car_idx <= r_car_idx + 1'b1;
        end
        StGrant: begin
          if (w_grant) r_ptr <= r_slot;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  for (genvar c = 0; c < N_CARS; c++) begin : g_out
    assign o_car_up_req[c*N_FLOORS +: N_FLOORS] = r_asgn[c][N_FLOORS-1:0];
    assign o_car_dn_req[c*N_FLOORS +: N_FLOORS] = r_asgn[c][NS-1:N_FLOORS];
  end

  assign o_up_pending = r_pend[N_FLOORS-1:0];
  assign o_dn_pending = r_pend[NS-1:N_FLOORS];
  assign o_busy       = (r_state != StIdle);

endmodule

// File: tb/tb_lift_group_dispatcher.sv
// Bench for lift_group_dispatcher (8 floors, 2 cars): expected grants are queued
// when calls are pressed and compared as new request bits appear.
module tb_lift_group_dispatcher;

  localparam int NF = 8;
  localparam int NC = 2;
  localparam int FW = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic [NF-1:0]    up_rqst, dn_rqst;
  logic [NC*FW-1:0] car_flr;
  logic [NC-1:0]    car_dir, car_motion, car_avail, car_up_clr, car_dn_clr;
  logic [NC*NF-1:0] car_up_req, car_dn_req;
  logic [NF-1:0]    up_pending, dn_pending;
  logic             busy;

  int cyc = 0;
  int busy_cnt = 0;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {int car; int slot; int lat;} exp_t;
  exp_t sb[$];

  lift_group_dispatcher #(.N_FLOORS(NF), .N_CARS(NC)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_up_rqst    (up_rqst),
    .i_dn_rqst    (dn_rqst),
    .i_car_flr    (car_flr),
    .i_car_dir    (car_dir),
    .i_car_motion (car_motion),
    .i_car_avail  (car_avail),
    .i_car_up_clr (car_up_clr),
    .i_car_dn_clr (car_dn_clr),
    .o_car_up_req (car_up_req),
    .o_car_dn_req (car_dn_req),
    .o_up_pending (up_pending),
    .o_dn_pending (dn_pending),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy) busy_cnt <= busy_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_car(input int c, input int flr, input bit dir, input bit mot);
    car_flr[c*FW +: FW] = FW'(flr);
    car_dir[c]          = dir;
    car_motion[c]       = mot;
  endtask

  // Reset with car0 idle at floor 0 and car1 idle at floor 7.
  task automatic do_reset();
    reset = 1'b0;
    up_rqst = '0; dn_rqst = '0;
    car_avail = '1; car_up_clr = '0; car_dn_clr = '0;
    set_car(0, 0, 1'b0, 1'b0);
    set_car(1, 7, 1'b0, 1'b0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    sb.delete();
  endtask

  // Press buttons so they are sampled at the next edge; t is that edge's cycle.
  task automatic press(input logic [NF-1:0] up, input logic [NF-1:0] dn, output int t);
    up_rqst = up;
    dn_rqst = dn;
    tick();
    t = cyc;
    up_rqst = '0;
    dn_rqst = '0;
  endtask

  task automatic pop_exp(output exp_t e);
    if (sb.size() == 0) e = '{car: -1, slot: -1, lat: -1};
    else e = sb.pop_front();
  endtask

  // Watch for the next newly set request bit on any car (bounded wait).
  task automatic wait_grant(input int t0, input int budget, output bit ok, output int car,
                            output int slot, output int lat);
    logic [2*NF-1:0] prev [NC];
    logic [2*NF-1:0] cur;
    ok = 1'b0; car = -1; slot = -1; lat = -1;
    for (int c = 0; c < NC; c++) prev[c] = {car_dn_req[c*NF +: NF], car_up_req[c*NF +: NF]};
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      for (int c = 0; c < NC; c++) begin
        cur = {car_dn_req[c*NF +: NF], car_up_req[c*NF +: NF]};
        for (int s = 0; s < 2*NF; s++) begin
          if (!ok && cur[s] && !prev[c][s]) begin
            ok = 1'b1; car = c; slot = s; lat = cyc - t0;
          end
        end
        prev[c] = cur;
      end
    end
  endtask

  task automatic test_reset();
    int t, car, slot, lat; bit ok; exp_t e;
    reset = 1'b0;
    up_rqst = '1; dn_rqst = '1;
    car_avail = '1; car_up_clr = '0; car_dn_clr = '0;
    set_car(0, 0, 1'b0, 1'b0);
    set_car(1, 7, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({up_pending, dn_pending} !== 16'h0) begin
      n_errors++; $display("FAIL reset_pending: got %h want 0000", {up_pending, dn_pending});
    end
    n_checks++;
    if ({car_up_req, car_dn_req} !== 32'h0) begin
      n_errors++; $display("FAIL reset_req: got %h want 0", {car_up_req, car_dn_req});
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++; $display("FAIL reset_busy: got %b want 0", busy);
    end
    @(posedge clk); #1;
    up_rqst = '0; dn_rqst = '0; reset = 1'b1;
    tick();
    sb.delete();
    busy_cnt = 0;
    press(8'h04, 8'h00, t);
    sb.push_back('{car: 0, slot: 2, lat: 5});
    @(negedge clk);
    n_checks++;
    if (up_pending !== 8'h04) begin
      n_errors++; $display("FAIL first_lamp: got %h want 04", up_pending);
    end
    wait_grant(t, 20, ok, car, slot, lat);
    pop_exp(e);
    n_checks++;
    if (!ok || car !== e.car || slot !== e.slot || lat !== e.lat) begin
      n_errors++;
      $display("FAIL first_grant: got ok=%0b car=%0d slot=%0d lat=%0d want car=%0d slot=%0d lat=%0d",
               ok, car, slot, lat, e.car, e.slot, e.lat);
    end
    n_checks++;
    if (car_up_req[7:0] !== 8'h04) begin
      n_errors++; $display("FAIL first_req: got %h want 04", car_up_req[7:0]);
    end
    repeat (3) tick();
    n_checks++;
    if (busy_cnt !== 4) begin
      n_errors++; $display("FAIL busy_len: got %0d want 4", busy_cnt);
    end
  endtask

  task automatic test_direction();
    int t, car, slot, lat; bit ok; exp_t e;
    do_reset();
    set_car(0, 1, 1'b1, 1'b1);
    set_car(1, 5, 1'b1, 1'b1);
    press(8'h00, 8'h08, t);
    sb.push_back('{car: 0, slot: 11, lat: 5});
    wait_grant(t, 20, ok, car, slot, lat);
    pop_exp(e);
    n_checks++;
    if (!ok || car !== e.car || slot !== e.slot || lat !== e.lat) begin
      n_errors++;
      $display("FAIL penalty_tie: got ok=%0b car=%0d slot=%0d lat=%0d want car=%0d slot=%0d lat=%0d",
               ok, car, slot, lat, e.car, e.slot, e.lat);
    end
    n_checks++;
    if (car_dn_req[7:0] !== 8'h08) begin
      n_errors++; $display("FAIL penalty_tie_req: got %h want 08", car_dn_req[7:0]);
    end
    set_car(1, 5, 1'b1, 1'b0);
    press(8'h00, 8'h10, t);
    sb.push_back('{car: 1, slot: 12, lat: 5});
    wait_grant(t, 20, ok, car, slot, lat);
    pop_exp(e);
    n_checks++;
    if (!ok || car !== e.car || slot !== e.slot || lat !== e.lat) begin
      n_errors++;
      $display("FAIL stopped_car: got ok=%0b car=%0d slot=%0d lat=%0d want car=%0d slot=%0d lat=%0d",
               ok, car, slot, lat, e.car, e.slot, e.lat);
    end
    n_checks++;
    if (car_dn_req[15:8] !== 8'h10) begin
      n_errors++; $display("FAIL stopped_car_req: got %h want 10", car_dn_req[15:8]);
    end
  endtask

  task automatic test_clear_precedence();
    int t, car, slot, lat; bit ok; exp_t e;
    do_reset();
    press(8'h04, 8'h00, t);
    sb.push_back('{car: 0, slot: 2, lat: 5});
    wait_grant(t, 20, ok, car, slot, lat);
    pop_exp(e);
    n_checks++;
    if (!ok || car !== e.car || slot !== e.slot || lat !== e.lat) begin
      n_errors++;
      $display("FAIL clr_setup: got ok=%0b car=%0d slot=%0d lat=%0d want car=%0d slot=%0d lat=%0d",
               ok, car, slot, lat, e.car, e.slot, e.lat);
    end
    @(posedge clk); #1;
    set_car(0, 2, 1'b0, 1'b0);
    car_up_clr = 2'b01;
    up_rqst = 8'h04;
    tick();
    car_up_clr = '0;
    up_rqst = '0;
    @(negedge clk);
    n_checks++;
    if (up_pending !== 8'h00) begin
      n_errors++; $display("FAIL clr_lamp: got %h want 00", up_pending);
    end
    n_checks++;
    if (car_up_req !== 16'h0) begin
      n_errors++; $display("FAIL clr_req: got %h want 0000", car_up_req);
    end
    @(posedge clk); #1;
    busy_cnt = 0;
    repeat (8) tick();
    n_checks++;
    if (busy_cnt !== 0 || up_pending !== 8'h00) begin
      n_errors++; $display("FAIL clr_quiet: got busy_cnt=%0d lamp=%h want 0 and 00",
                           busy_cnt, up_pending);
    end
  endtask

  task automatic test_dropout();
    int t, car, slot, lat; bit ok; exp_t e;
    do_reset();
    press(8'h00, 8'h40, t);
    sb.push_back('{car: 1, slot: 14, lat: 5});
    wait_grant(t, 20, ok, car, slot, lat);
    pop_exp(e);
    n_checks++;
    if (!ok || car !== e.car || slot !== e.slot || lat !== e.lat) begin
      n_errors++;
      $display("FAIL drop_setup: got ok=%0b car=%0d slot=%0d lat=%0d want car=%0d slot=%0d lat=%0d",
               ok, car, slot, lat, e.car, e.slot, e.lat);
    end
    @(posedge clk); #1;
    car_avail = 2'b01;
    tick();
    t = cyc;
    sb.push_back('{car: 0, slot: 14, lat: 5});
    @(negedge clk);
    n_checks++;
    if (car_dn_req[15:8] !== 8'h00) begin
      n_errors++; $display("FAIL drop_req: got %h want 00", car_dn_req[15:8]);
    end
    n_checks++;
    if (dn_pending !== 8'h40) begin
      n_errors++; $display("FAIL drop_lamp: got %h want 40", dn_pending);
    end
    wait_grant(t, 20, ok, car, slot, lat);
    pop_exp(e);
    n_checks++;
    if (!ok || car !== e.car || slot !== e.slot || lat !== e.lat) begin
      n_errors++;
      $display("FAIL redispatch: got ok=%0b car=%0d slot=%0d lat=%0d want car=%0d slot=%0d lat=%0d",
               ok, car, slot, lat, e.car, e.slot, e.lat);
    end
    car_avail = '1;
  endtask

  task automatic test_mask_round_robin();
    int t, car, slot, lat; bit ok; exp_t e;
    do_reset();
    busy_cnt = 0;
    press(8'h80, 8'h01, t);
    @(negedge clk);
    n_checks++;
    if ({up_pending, dn_pending} !== 16'h0) begin
      n_errors++; $display("FAIL mask_lamps: got %h want 0000", {up_pending, dn_pending});
    end
    repeat (4) tick();
    n_checks++;
    if (busy_cnt !== 0) begin
      n_errors++; $display("FAIL mask_busy: got %0d busy cycles want 0", busy_cnt);
    end
    press(8'h2A, 8'h00, t);
    sb.push_back('{car: 0, slot: 1, lat: 5});
    sb.push_back('{car: 0, slot: 3, lat: 10});
    sb.push_back('{car: 1, slot: 5, lat: 15});
    for (int g = 0; g < 3; g++) begin
      wait_grant(t, 30, ok, car, slot, lat);
      pop_exp(e);
      n_checks++;
      if (!ok || car !== e.car || slot !== e.slot || lat !== e.lat) begin
        n_errors++;
        $display("FAIL rr_grant%0d: got ok=%0b car=%0d slot=%0d lat=%0d want car=%0d slot=%0d lat=%0d",
                 g, ok, car, slot, lat, e.car, e.slot, e.lat);
      end
    end
  endtask

  task automatic test_abort();
    int t, car, slot, lat; bit ok; exp_t e;
    do_reset();
    press(8'h10, 8'h00, t);
    tick();
    tick();
    set_car(1, 4, 1'b0, 1'b0);
    car_up_clr = 2'b10;
    tick();
    car_up_clr = '0;
    @(negedge clk);
    n_checks++;
    if (up_pending !== 8'h00) begin
      n_errors++; $display("FAIL abort_lamp: got %h want 00", up_pending);
    end
    repeat (6) tick();
    n_checks++;
    if (car_up_req !== 16'h0 || busy !== 1'b0) begin
      n_errors++; $display("FAIL abort_nogrant: got req=%h busy=%b want 0000 and 0",
                           car_up_req, busy);
    end
    set_car(1, 7, 1'b0, 1'b0);
    // Unchanged pointer means the search still starts at slot 0, so floor 1 beats floor 6.
    press(8'h42, 8'h00, t);
    sb.push_back('{car: 0, slot: 1, lat: 5});
    sb.push_back('{car: 1, slot: 6, lat: 10});
    for (int g = 0; g < 2; g++) begin
      wait_grant(t, 30, ok, car, slot, lat);
      pop_exp(e);
      n_checks++;
      if (!ok || car !== e.car || slot !== e.slot || lat !== e.lat) begin
        n_errors++;
        $display("FAIL abort_ptr%0d: got ok=%0b car=%0d slot=%0d lat=%0d want car=%0d slot=%0d lat=%0d",
                 g, ok, car, slot, lat, e.car, e.slot, e.lat);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    up_rqst = '0; dn_rqst = '0;
    car_flr = '0; car_dir = '0; car_motion = '0;
    car_avail = '1; car_up_clr = '0; car_dn_clr = '0;
    test_reset();
    test_direction();
    test_clear_precedence();
    test_dropout();
    test_mask_round_robin();
    test_abort();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
